// File: rtl/fsm_responder.sv
// fsm_responder: responder side of the linked-state-machine handshake; raises ready a programmable delay after start.
// Optional acknowledge timeout (ERR state) is compiled in with `define FSM_RESP_TIMEOUT_EN.
`default_nettype none

module fsm_responder #(
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         start,
    input  logic         y,
    input  logic [W-1:0] delay,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] count
);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_CNT  = 5'b00010,
        S_RDY  = 5'b00100,
        S_ACK  = 5'b01000,
        S_ERR  = 5'b10000
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] counter;
    logic [W-1:0] counter_nx;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("fsm_responder: TIMEOUT must be >= 1");
    end

`ifdef FSM_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nx;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            counter <= '0;
`ifdef FSM_RESP_TIMEOUT_EN
            tcnt    <= '0;
`endif
        end else begin
            state   <= state_nx;
            counter <= counter_nx;
`ifdef FSM_RESP_TIMEOUT_EN
            tcnt    <= tcnt_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = S_IDLE;
        counter_nx = counter;
`ifdef FSM_RESP_TIMEOUT_EN
        tcnt_nx    = tcnt;
`endif
        if (clr) begin
            state_nx   = S_IDLE;
            counter_nx = '0;
`ifdef FSM_RESP_TIMEOUT_EN
            tcnt_nx    = '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx   = S_CNT;
                        counter_nx = delay;
                    end else begin
                        state_nx   = S_IDLE;
                    end
                end
                S_CNT: begin
                    // Counter holds at zero on the exit cycle, so it never wraps.
                    if (counter == '0) begin
                        state_nx = S_RDY;
`ifdef FSM_RESP_TIMEOUT_EN
                        tcnt_nx  = '0;
`endif
                    end else begin
                        state_nx   = S_CNT;
                        counter_nx = counter - W'(1);
                    end
                end
                S_RDY: begin
                    if (y) begin
                        state_nx = S_ACK;
                    end else begin
`ifdef FSM_RESP_TIMEOUT_EN
                        if (tcnt == TW'(TIMEOUT - 1)) begin
                            state_nx = S_ERR;
                        end else begin
                            state_nx = S_RDY;
                            tcnt_nx  = tcnt + TW'(1);
                        end
`else
                        state_nx = S_RDY;
`endif
                    end
                end
                S_ACK: begin
                    state_nx = y ? S_ACK : S_IDLE;
                end
                S_ERR: begin
`ifdef FSM_RESP_TIMEOUT_EN
                    state_nx = S_ERR;
`else
                    state_nx = S_IDLE;
`endif
                end
                default: begin
                    state_nx   = S_IDLE;
                    counter_nx = '0;
                end
            endcase
        end
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        err   = 1'b0;
        case (state)
            S_CNT:   busy  = 1'b1;
            S_RDY:   ready = 1'b1;
            S_ACK:   done  = 1'b1;
`ifdef FSM_RESP_TIMEOUT_EN
            S_ERR:   err   = 1'b1;
`endif
            default: ;
        endcase
    end

    assign count = counter;

endmodule

`default_nettype wire

// File: tb/tb_fsm_responder.sv
// Bench for fsm_responder: directed handshake scenarios plus randomized traffic against a timeline model.
`default_nettype none

module tb_fsm_responder;

    localparam int W       = 8;
    localparam int TIMEOUT = 16;
`ifdef FSM_RESP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         clr   = 1'b0;
    logic         start = 1'b0;
    logic         y     = 1'b0;
    logic [W-1:0] delay = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] count;

    int vectors     = 0;
    int miscompares = 0;

    fsm_responder #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .start (start),
        .y     (y),
        .delay (delay),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: a transaction is a start time plus elapsed cycles; phases follow from arithmetic on those.
    bit m_active = 1'b0;
    bit m_acked  = 1'b0;
    bit m_err    = 1'b0;
    int m_el     = 0;
    int m_dly    = 0;
    int m_wait   = 0;

    task automatic m_clear();
        m_active = 1'b0;
        m_acked  = 1'b0;
        m_err    = 1'b0;
        m_el     = 0;
        m_dly    = 0;
        m_wait   = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset || clr) begin
            m_clear();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_el     = 0;
                m_dly    = int'(delay);
                m_wait   = 0;
            end
        end else if (m_err) begin
            m_err = 1'b1;
        end else if (m_el <= m_dly) begin
            m_el++;
        end else if (!m_acked) begin
            if (y)                                   m_acked = 1'b1;
            else if (TO_EN && m_wait == TIMEOUT - 1) m_err   = 1'b1;
            else                                     m_wait++;
        end else if (!y) begin
            m_clear();
        end
    end

    always @(negedge clk) begin
        int e_busy, e_ready, e_done, e_err, e_count;
        e_busy  = (m_active && m_el <= m_dly) ? 1 : 0;
        e_count = (e_busy != 0) ? (m_dly - m_el) : 0;
        e_ready = (m_active && m_el > m_dly && !m_acked && !m_err) ? 1 : 0;
        e_done  = m_acked ? 1 : 0;
        e_err   = m_err ? 1 : 0;
        chk("busy",  int'(busy),  e_busy);
        chk("ready", int'(ready), e_ready);
        chk("done",  int'(done),  e_done);
        chk("err",   int'(err),   e_err);
        chk("count", int'(count), e_count);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // DELAY=3: count 3,2,1,0 while busy, then ready, ack, idle
        start = 1'b1; delay = 8'd3;
        @(negedge clk);
        chk("d3_busy", int'(busy), 1);
        chk("d3_count3", int'(count), 3);
        #1 start = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk);
            chk("d3_count", int'(count), i);
        end
        @(negedge clk);
        chk("d3_ready", int'(ready), 1);
        #1 y = 1'b1;
        @(negedge clk);
        chk("d3_done", int'(done), 1);
        chk("d3_ready_off", int'(ready), 0);
        #1 y = 1'b0;
        @(negedge clk);
        chk("d3_idle", int'(done | busy | ready), 0);

        // DELAY=0 with y raised two cycles after ready
        #1 start = 1'b1; delay = 8'd0;
        @(negedge clk);
        chk("d0_busy", int'(busy), 1);
        #1 start = 1'b0;
        @(negedge clk);
        chk("d0_ready1", int'(ready), 1);
        @(negedge clk);
        chk("d0_ready2", int'(ready), 1);
        #1 y = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("d0_done", int'(done), 1);
        end
        #1 y = 1'b0;
        @(negedge clk);
        chk("d0_idle", int'(done | ready), 0);

        // DELAY=10, start held during count (ignored), clr after 4 count cycles
        #1 start = 1'b1; delay = 8'd10;
        for (int i = 10; i >= 7; i--) begin
            @(negedge clk);
            chk("d10_count", int'(count), i);
        end
        #1 clr = 1'b1; delay = 8'd200;
        @(negedge clk);
        chk("clr_count", int'(count), 0);
        chk("clr_busy", int'(busy), 0);
        #1 clr = 1'b0; start = 1'b0;

        // asynchronous reset mid-count
        @(negedge clk);
        #1 start = 1'b1; delay = 8'd5;
        @(negedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_ready", int'(ready), 0);
        @(negedge clk);
        #1 reset = 1'b0;

        // y held low for 100+ cycles in ready
        start = 1'b1; delay = 8'd0;
        @(negedge clk);
        #1 start = 1'b0;
        repeat (101) @(negedge clk);
        chk("long_ready", int'(ready), TO_EN ? 0 : 1);
        chk("long_err", int'(err), TO_EN ? 1 : 0);
        #1 clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            start = ($urandom_range(0, 3) == 0);
            clr   = ($urandom_range(0, 24) == 0);
            y     = ($urandom_range(0, 2) == 0);
            delay = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 255))
                                                  : W'($urandom_range(0, 6));
            @(negedge clk);
            #1;
        end
        start = 1'b0; clr = 1'b0; y = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
